// File: rtl/sram_bus_slave_if.sv
// Bus-side request/response bundle between a bus master and the SRAM responder.
interface sram_bus_slave_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic        stall;
  logic [31:0] data_rd;
  logic [31:0] data_rd_2;
  logic [5:0]  interrupt;

  modport master (
    output address, read, write, data_wr, mask,
    input  stall, data_rd, data_rd_2, interrupt
  );

  modport slave (
    input  address, read, write, data_wr, mask,
    output stall, data_rd, data_rd_2, interrupt
  );
endinterface

// File: rtl/sram_bus_slave.sv
// Bus slave serving word reads/writes from a 32-bit asynchronous SRAM.
// All SRAM-side outputs are registered; only stall is combinational on the request.
module sram_bus_slave #(
  parameter int READ_WAIT_CYCLES   = 1,
  parameter int WRITE_PULSE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_bus_slave_if.slave      bus,
  output logic [19:0]          sram_address,
  output logic [3:0]           sram_be_n,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [31:0]          sram_data_o,
  output logic                 sram_data_oe,
  input  logic [31:0]          sram_data_i
);

  typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  localparam int MAX_C = (READ_WAIT_CYCLES > WRITE_PULSE_CYCLES) ? READ_WAIT_CYCLES
                                                                  : WRITE_PULSE_CYCLES;
  localparam int CW = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(READ_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WRITE_PULSE_CYCLES - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [19:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   data_rd_q;
  logic [3:0]    be_n_q;
  logic          ce_n_q, oe_n_q, we_n_q, doe_q;

  wire unused_addr = ^{bus.address[31:22], bus.address[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_rd_q <= '0;
      be_n_q    <= 4'b1111;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      doe_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Write takes priority when both requests arrive together.
          if (bus.write) begin
            addr_q  <= bus.address[21:2];
            wdata_q <= bus.data_wr;
            be_n_q  <= ~bus.mask;
            ce_n_q  <= 1'b0;
            doe_q   <= 1'b1;
            state_q <= WR_SETUP;
          end else if (bus.read) begin
            addr_q  <= bus.address[21:2];
            wdata_q <= bus.data_wr;
            be_n_q  <= 4'b0000;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          if (cnt_q == RD_LAST) begin
            data_rd_q <= sram_data_i;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            be_n_q    <= 4'b1111;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WR_SETUP: begin
          we_n_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt_q == WR_LAST) begin
            we_n_q  <= 1'b1;
            state_q <= WR_HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WR_HOLD: begin
          ce_n_q  <= 1'b1;
          be_n_q  <= 4'b1111;
          doe_q   <= 1'b0;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // DONE is the single cycle where the master sees the access complete.
  assign bus.stall     = (bus.read | bus.write) && (state_q != DONE);
  assign bus.data_rd   = data_rd_q;
  assign bus.data_rd_2 = '0;
  assign bus.interrupt = '0;

  assign sram_address = addr_q;
  assign sram_be_n    = be_n_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_data_o  = wdata_q;
  assign sram_data_oe = doe_q;

endmodule

// File: tb/tb_sram_bus_slave.sv
// Directed bench: two responders (1/1 and 3/2 wait settings) each on a small SRAM model.
module tb_sram_bus_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_bus_slave_if bus0();
  sram_bus_slave_if bus1();

  logic [1:0]       rd, wr;
  logic [1:0][31:0] adr, wdat;
  logic [1:0][3:0]  msk;
  wire  [1:0]       stall, ce_n, oe_n, we_n, doe;
  wire  [1:0][19:0] saddr;
  wire  [1:0][3:0]  be_n;
  wire  [1:0][31:0] drd, sdo, sdi;

  assign bus0.read = rd[0];  assign bus0.write = wr[0];
  assign bus0.address = adr[0]; assign bus0.data_wr = wdat[0]; assign bus0.mask = msk[0];
  assign bus1.read = rd[1];  assign bus1.write = wr[1];
  assign bus1.address = adr[1]; assign bus1.data_wr = wdat[1]; assign bus1.mask = msk[1];
  assign stall[0] = bus0.stall; assign drd[0] = bus0.data_rd;
  assign stall[1] = bus1.stall; assign drd[1] = bus1.data_rd;

  sram_bus_slave u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .sram_address(saddr[0]), .sram_be_n(be_n[0]), .sram_ce_n(ce_n[0]),
    .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_data_o(sdo[0]),
    .sram_data_oe(doe[0]), .sram_data_i(sdi[0])
  );

  sram_bus_slave #(.READ_WAIT_CYCLES(3), .WRITE_PULSE_CYCLES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .sram_address(saddr[1]), .sram_be_n(be_n[1]), .sram_ce_n(ce_n[1]),
    .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_data_o(sdo[1]),
    .sram_data_oe(doe[1]), .sram_data_i(sdi[1])
  );

  // Async SRAM model: drives data while selected and output-enabled, writes enabled bytes.
  logic [31:0] mem [2][256];
  assign sdi[0] = (!ce_n[0] && !oe_n[0]) ? mem[0][saddr[0][7:0]] : 32'h0;
  assign sdi[1] = (!ce_n[1] && !oe_n[1]) ? mem[1][saddr[1][7:0]] : 32'h0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (!ce_n[k] && !we_n[k])
        for (int b = 0; b < 4; b++)
          if (!be_n[k][b]) mem[k][saddr[k][7:0]][8*b +: 8] <= sdo[k][8*b +: 8];
  end

  typedef struct { logic [31:0] rd; int stl; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic [31:0] exp_rd, input int exp_stl,
                        output int oe_c, output int we_c, output int doe_c,
                        output logic [19:0] a_seen, output logic [3:0] be_seen);
    int n;
    bit cont, done;
    exp_t e;
    e.rd = exp_rd; e.stl = exp_stl;
    sb.push_back(e);
    @(posedge clk); #1;
    rd[k] = r; wr[k] = w; adr[k] = a; wdat[k] = d; msk[k] = m;
    n = 0; oe_c = 0; we_c = 0; doe_c = 0; cont = 0; done = 0;
    a_seen = '0; be_seen = 4'b1111;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!stall[k]) done = 1;
      else begin
        n++;
        if (!oe_n[k]) oe_c++;
        if (!we_n[k]) we_c++;
        if (doe[k])   doe_c++;
        if (!ce_n[k]) begin a_seen = saddr[k]; be_seen = be_n[k]; end
        if (!oe_n[k] && doe[k]) cont = 1;
      end
    end
    chk("completed", done, 1);
    e = sb.pop_front();
    chk("stall_len", n, e.stl);
    chk("data_rd", drd[k], e.rd);
    chk("no_contention", cont, 0);
    chk("done_ce_n", ce_n[k], 1);
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc, wc, dc;
    logic [19:0] as;
    logic [3:0]  bs;
    rd = '0; wr = '0; adr = '0; wdat = '0; msk = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) mem[k][i] = 32'hCCCC_CCCC;
    mem[0][4]  = 32'hDEAD_BEEF;
    mem[1][1]  = 32'h0BAD_F00D;
    mem[1][16] = 32'h55AA_1234;

    // Reset held while requests toggle
    repeat (2) @(posedge clk);
    #1 rd[0] = 1'b1; wr[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ce_n", ce_n[0], 1);
    chk("rst_oe_n", oe_n[0], 1);
    chk("rst_we_n", we_n[0], 1);
    chk("rst_be_n", be_n[0], 4'hF);
    chk("rst_doe", doe[0], 0);
    chk("rst_data_rd", drd[0], 0);
    chk("rst_addr", saddr[0], 0);
    chk("rst_sdo", sdo[0], 0);
    chk("rst_we_n_u1", we_n[1], 1);
    chk("rst_doe_u1", doe[1], 0);
    chk("rst_stall_req", stall[0], 1);
    #1 rd[0] = 1'b0; wr[1] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("stall_no_req", stall[0], 0);
    chk("data_rd_2", bus0.data_rd_2, 0);
    chk("interrupt", bus0.interrupt, 0);

    // Single read, 1 wait cycle
    access(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, oc, wc, dc, as, bs);
    chk("rd_addr", as, 20'h00004);
    chk("rd_oe_cycles", oc, 1);
    chk("rd_doe_cycles", dc, 0);
    chk("rd_we_cycles", wc, 0);
    idle(0);

    // Masked write, then read-back
    access(0, 0, 1, 32'h0000_0020, 32'h1234_5678, 4'b0101, 32'hDEAD_BEEF, 4, oc, wc, dc, as, bs);
    chk("wr_addr", as, 20'h00008);
    chk("wr_be_n", bs, 4'b1010);
    chk("wr_we_cycles", wc, 1);
    chk("wr_doe_cycles", dc, 3);
    chk("wr_oe_cycles", oc, 0);
    idle(0);
    access(0, 1, 0, 32'h0000_0020, 32'h0, 4'h0, 32'hCC34_CC78, 2, oc, wc, dc, as, bs);
    idle(0);

    // Read and write together: write wins; upper/low address bits ignored
    access(0, 1, 1, 32'hFFC0_0033, 32'hA5A5_A5A5, 4'hF, 32'hCC34_CC78, 4, oc, wc, dc, as, bs);
    chk("rw_oe_cycles", oc, 0);
    chk("rw_we_cycles", wc, 1);
    chk("rw_addr", as, 20'h0000C);
    idle(0);
    chk("rw_mem", mem[0][12], 32'hA5A5_A5A5);

    // Empty mask: full cycle, no bytes change
    access(0, 0, 1, 32'h0000_0034, 32'hFFFF_FFFF, 4'h0, 32'hCC34_CC78, 4, oc, wc, dc, as, bs);
    chk("m0_be_n", bs, 4'hF);
    chk("m0_we_cycles", wc, 1);
    idle(0);
    chk("m0_mem", mem[0][13], 32'hCCCC_CCCC);

    // Back-to-back read then write on the 3/2 responder
    access(1, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 32'h55AA_1234, 4, oc, wc, dc, as, bs);
    chk("b2b_rd_oe", oc, 3);
    access(1, 0, 1, 32'h0000_0044, 32'h1122_3344, 4'hF, 32'h55AA_1234, 5, oc, wc, dc, as, bs);
    chk("b2b_wr_we", wc, 2);
    chk("b2b_wr_doe", dc, 4);
    chk("b2b_wr_oe", oc, 0);
    idle(1);
    chk("b2b_mem", mem[1][17], 32'h1122_3344);

    // Reset in the middle of the write pulse
    @(posedge clk); #1;
    wr[1] = 1'b1; adr[1] = 32'h0000_0048; wdat[1] = 32'h99; msk[1] = 4'hF;
    repeat (3) @(negedge clk);
    chk("pulse_we_n", we_n[1], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we_n", we_n[1], 1);
    chk("arst_ce_n", ce_n[1], 1);
    chk("arst_doe", doe[1], 0);
    chk("arst_be_n", be_n[1], 4'hF);
    wr[1] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("arst_data_rd", drd[1], 0);
    access(1, 1, 0, 32'h0000_0004, 32'h0, 4'h0, 32'h0BAD_F00D, 4, oc, wc, dc, as, bs);
    chk("post_rst_addr", as, 20'h00001);
    chk("post_rst_oe", oc, 3);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
